// File: rtl/sub_nbit_serial.sv
// Bit-serial subtractor: diff = a - b - b_in, computed LSB-first through a single
// full-adder cell (a + ~b + ~b_in) over WIDTH cycles, with valid/ready handshakes.
module sub_nbit_serial #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               c_q, c_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               b_out_q, b_out_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic               nb0;
  logic               sum;
  logic               carry;
  logic [WIDTH-1:0]   res_shift;

  // The shared full-adder cell, operating on bit 0 of the operand shifters.
  always_comb begin
    nb0       = ~b_q[0];
    sum       = a_q[0] ^ nb0 ^ c_q;
    carry     = (a_q[0] & nb0) | (a_q[0] & c_q) | (nb0 & c_q);
    res_shift = {sum, res_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    diff_d      = diff_q;
    b_out_d     = b_out_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          c_d        = ~b_in;
          cnt_d      = '0;
          res_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        res_d = res_shift;
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carry;
        cnt_d = cnt_q + CNT_W'(1);
        // Last bit: carry into vs. out of the MSB gives signed overflow.
        if (cnt_q == LAST_BIT) begin
          diff_d      = res_shift;
          b_out_d     = ~carry;
          ovf_d       = c_q ^ carry;
          zero_d      = (res_shift == '0);
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      diff_q      <= '0;
      b_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      diff_q      <= diff_d;
      b_out_q     <= b_out_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign b_out     = b_out_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
